rect_source: RTL and testbench
==============================

# rect_source

Producer end of the dav_/rfd handshake used by the perimeter unit. On a start pulse it generates a fixed sequence of rectangle side pairs (a, b), offers each one to the consumer with the active-low dav_/rfd protocol, samples the returned perimeter p after each transaction, and counts mismatches against the expected 2·(a+b). It sits in front of the perimeter unit as its stimulus source and on-chip self-check.

## Interface
- N_ITEMS, 32, pairs per run; legal range 1..32
- A_OFF, 3, offset added to index bits [4:1] to form a
- B_OFF, 1, offset added to index bits [3:0] to form b
- SETUP_CYCLES, 1, cycles a/b are held stable before dav_ falls; legal range 1..7
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- rfd  in  1  consumer ready-for-data, active high
- p  in  6  consumer perimeter result
- a  out  4  side a offered to consumer
- b  out  4  side b offered to consumer
- dav_  out  1  data-available, active low
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when the last item has been checked
- err_count  out  6  mismatches in the current/last run, saturating at 63
- last_p  out  6  last sampled p

## Operation
- Index i (5 bits) runs 0..N_ITEMS-1. a = i[4:1]+A_OFF mod 16; b = i[3:0]+B_OFF mod 16; expected = 2·(a+b) mod 64 (6-bit, carries dropped).
- States: IDLE, SETUP, REQ, ACK, CHECK, DONE.
- IDLE: dav_=1, a=b=0. start=1 → SETUP, i=0, err_count=0, a/b loaded for i=0, busy=1.
- SETUP: hold a/b for SETUP_CYCLES cycles and until rfd=1 is sampled; then → REQ.
- REQ: dav_=0, a/b stable; stay until rfd=0 is sampled; then → ACK.
- ACK: dav_=1, a=b=0; stay until rfd=1 is sampled; then → CHECK.
- CHECK (one cycle): capture p into last_p; if p≠expected, err_count+1 (saturate at 63). If i=N_ITEMS-1 → DONE, else i+1, load next a/b, → SETUP.
- DONE (one cycle): done=1, busy=0; → IDLE. err_count and last_p hold until next start.
- start while busy is ignored. start in DONE is ignored.
- Reset values: dav_=1, a=0, b=0, busy=0, done=0, err_count=0, last_p=0, state IDLE, i=0. Reset mid-transaction returns dav_ to 1 on the same edge; no partial result is checked.

## Timing
- start sampled at edge k → a/b valid and busy=1 after edge k; dav_ falls after edge k+SETUP_CYCLES at the earliest.
- dav_ never falls while rfd=0; dav_ rises on the edge after rfd=0 is sampled; a/b change only while dav_=1.
- p sampled one edge after rfd=1 is sampled in ACK (CHECK cycle); consumer must have p valid by its rfd rise.
- Minimum per-item period with an immediate consumer: SETUP_CYCLES+4 cycles.
- rfd glitches within a state are ignored except as sampled at clock edges; no combinational path from any input to any output.

## Configuration
- RECT_SOURCE_TIMEOUT_EN defined: 8-bit watchdog counts cycles spent in SETUP, REQ or ACK; reaching 255 forces dav_=1, sets sticky output port timeout (1 bit, reset 0, cleared by start) and goes to DONE with done pulse. Watchdog clears on every state change.
- Not defined: no watchdog, no timeout port; the block waits indefinitely.

## Test plan
- Reset: hold reset 2 cycles → dav_=1, a=b=0, busy=0, err_count=0, last_p=0.
- Full run, correct consumer model (rfd drops 2 cycles after dav_=0, p=2·(a+b), rfd rises 3 cycles later) → 32 transactions, first pair a=3 b=1, last a=2 b=0 (wrap), done pulses once, err_count=0.
- Faulty consumer returns p+1 on items 5 and 17 → err_count=2; last_p=expected of item 31 = 4.
- Consumer holds rfd=0 at start for 10 cycles → dav_ stays 1 until rfd=1 is sampled; no handshake violation.
- Reset asserted while dav_=0 in item 3 → dav_=1 after that edge, busy=0; new start restarts at i=0 with err_count=0.
- With RECT_SOURCE_TIMEOUT_EN: consumer never drops rfd → after 255 cycles in REQ, dav_=1, timeout=1, done pulse; next start clears timeout.

Source files
------------

// File: rtl/rect_source_if.sv
// -----------------------------------------------------------------------------
// rect_source_if
// Handshake bundle between the rectangle-pair producer (rect_source) and the
// perimeter unit that consumes the pairs.
//
// Signals
//   a     [3:0]  side a offered by the producer
//   b     [3:0]  side b offered by the producer
//   dav_         data-available, active low, driven by the producer
//   rfd          ready-for-data, active high, driven by the consumer
//   p     [5:0]  perimeter result returned by the consumer
//
// Modports
//   master : producer view (drives a, b, dav_; reads rfd, p)
//   slave  : consumer view (reads a, b, dav_; drives rfd, p)
// -----------------------------------------------------------------------------
interface rect_source_if;
   logic [3:0] a;
   logic [3:0] b;
   logic       dav_;
   logic       rfd;
   logic [5:0] p;

   modport master (output a, output b, output dav_, input rfd, input p);
   modport slave  (input a, input b, input dav_, output rfd, output p);
endinterface : rect_source_if

// File: rtl/rect_source.sv
// -----------------------------------------------------------------------------
// rect_source
// Stimulus source and on-chip checker for the perimeter unit. A start pulse
// launches a run of N_ITEMS rectangle side pairs. Each pair is offered over
// the active-low dav_/rfd handshake, the returned perimeter p is sampled once
// the consumer raises rfd again, and every p that differs from 2*(a+b)
// (6 bits, carries dropped) bumps a saturating error counter.
//
// Pair generation for index i (5 bits):
//   a = i[4:1] + A_OFF (mod 16),  b = i[3:0] + B_OFF (mod 16)
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   one-cycle pulse, starts a run when idle
//   bus        if   rect_source_if.master (a, b, dav_ out; rfd, p in)
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse after the last item has been checked
//   err_count  out  [5:0] mismatches in the current/last run, saturating at 63
//   last_p     out  [5:0] last sampled p
//   timeout    out  sticky watchdog flag (only with RECT_SOURCE_TIMEOUT_EN)
//
// Build option
//   RECT_SOURCE_TIMEOUT_EN : adds an 8-bit watchdog over SETUP/REQ/ACK and the
//   timeout port. When undefined the block waits on the consumer indefinitely.
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module rect_source #(
   parameter int N_ITEMS      = 32,  // 1..32
   parameter int A_OFF        = 3,
   parameter int B_OFF        = 1,
   parameter int SETUP_CYCLES = 1    // 1..7
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   rect_source_if.master bus,
   output logic          busy,
   output logic          done,
   output logic [5:0]    err_count,
   output logic [5:0]    last_p
`ifdef RECT_SOURCE_TIMEOUT_EN
   ,
   output logic          timeout
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_REQ,
      S_ACK,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [4:0] LAST_IDX   = 5'(N_ITEMS - 1);
   localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYCLES - 1);

   state_t     state_q,     state_d;
   logic [4:0] idx_q,       idx_d;
   logic [2:0] setup_cnt_q, setup_cnt_d;   // counts down remaining setup cycles
   logic [3:0] a_q,         a_d;
   logic [3:0] b_q,         b_d;
   logic       dav_n_q,     dav_n_d;
   logic       busy_q,      busy_d;
   logic       done_q,      done_d;
   logic [5:0] err_count_q, err_count_d;
   logic [5:0] last_p_q,    last_p_d;
`ifdef RECT_SOURCE_TIMEOUT_EN
   logic [7:0] wd_q,        wd_d;
   logic       timeout_q,   timeout_d;
`endif

   logic [5:0] expected_p;

   function automatic logic [3:0] side_a(input logic [4:0] i);
      return i[4:1] + 4'(A_OFF);
   endfunction

   function automatic logic [3:0] side_b(input logic [4:0] i);
      return i[3:0] + 4'(B_OFF);
   endfunction

   // a/b are zeroed while dav_ is high, so the reference is rebuilt from the
   // index rather than from the offered outputs. The 5-bit sum shifted left
   // fits 6 bits, so the mod-64 wrap is implicit.
   logic [4:0] side_sum;
   assign side_sum   = {1'b0, side_a(idx_q)} + {1'b0, side_b(idx_q)};
   assign expected_p = {side_sum, 1'b0};

   always_comb begin
      // NOTE: every _d starts from its held value so no branch leaves a
      // variable unassigned and no latch is inferred.
      state_d     = state_q;
      idx_d       = idx_q;
      setup_cnt_d = setup_cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      dav_n_d     = dav_n_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_count_d = err_count_q;
      last_p_d    = last_p_q;
`ifdef RECT_SOURCE_TIMEOUT_EN
      timeout_d   = timeout_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_SETUP;
               idx_d       = 5'd0;
               setup_cnt_d = SETUP_LAST;
               a_d         = side_a(5'd0);
               b_d         = side_b(5'd0);
               busy_d      = 1'b1;
               err_count_d = 6'd0;
`ifdef RECT_SOURCE_TIMEOUT_EN
               timeout_d   = 1'b0;
`endif
            end
         end

         S_SETUP: begin
            // The setup count runs regardless of rfd; the request is raised
            // only once both the count has expired and rfd is seen high.
            if (setup_cnt_q == 3'd0 && bus.rfd) begin
               state_d = S_REQ;
               dav_n_d = 1'b0;
            end else if (setup_cnt_q != 3'd0) begin
               setup_cnt_d = setup_cnt_q - 3'd1;
            end
         end

         S_REQ: begin
            if (!bus.rfd) begin
               state_d = S_ACK;
               dav_n_d = 1'b1;
               a_d     = 4'd0;
               b_d     = 4'd0;
            end
         end

         S_ACK: begin
            if (bus.rfd) begin
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            last_p_d = bus.p;
            if (bus.p != expected_p && err_count_q != 6'd63) begin
               err_count_d = err_count_q + 6'd1;
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d     = S_SETUP;
               idx_d       = idx_q + 5'd1;
               setup_cnt_d = SETUP_LAST;
               a_d         = side_a(idx_q + 5'd1);
               b_d         = side_b(idx_q + 5'd1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef RECT_SOURCE_TIMEOUT_EN
      // Watchdog restarts on every state change; the 255th consecutive cycle
      // in a waiting state abandons the run.
      wd_d = 8'd0;
      if (state_d == state_q &&
          (state_q == S_SETUP || state_q == S_REQ || state_q == S_ACK)) begin
         if (wd_q == 8'd254) begin
            state_d   = S_DONE;
            dav_n_d   = 1'b1;
            a_d       = 4'd0;
            b_d       = 4'd0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
         end else begin
            wd_d = wd_q + 8'd1;
         end
      end
`endif
   end

   always_ff @(posedge clock) begin
      // NOTE: every flop, index included, is reset so a reset in the middle of
      // a handshake drops dav_ back high on that same edge with no stale item.
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= 5'd0;
         setup_cnt_q <= 3'd0;
         a_q         <= 4'd0;
         b_q         <= 4'd0;
         dav_n_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_count_q <= 6'd0;
         last_p_q    <= 6'd0;
`ifdef RECT_SOURCE_TIMEOUT_EN
         wd_q        <= 8'd0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q     <= state_d;
         idx_q       <= idx_d;
         setup_cnt_q <= setup_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         dav_n_q     <= dav_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_count_q <= err_count_d;
         last_p_q    <= last_p_d;
`ifdef RECT_SOURCE_TIMEOUT_EN
         wd_q        <= wd_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign bus.a     = a_q;
   assign bus.b     = b_q;
   assign bus.dav_  = dav_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_count = err_count_q;
   assign last_p    = last_p_q;
`ifdef RECT_SOURCE_TIMEOUT_EN
   assign timeout   = timeout_q;
`endif

endmodule : rect_source

// File: tb/tb_rect_source.sv
// -----------------------------------------------------------------------------
// tb_rect_source
// Self-checking bench for rect_source. A behavioural consumer answers each
// dav_ request with configurable delays and optional wrong perimeters; the
// expected pair sequence, error count and last perimeter come from plain
// arithmetic on the item index. Table rows cover the fixed scenarios, random
// runs vary delays and fault masks, and hand sequences cover reset and the
// optional watchdog (RECT_SOURCE_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_rect_source;

   localparam int N_ITEMS = 32;
   localparam int BUDGET  = 4000;

   logic       clock;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic [5:0] err_count;
   logic [5:0] last_p;
`ifdef RECT_SOURCE_TIMEOUT_EN
   logic       timeout;
`endif

   rect_source_if bus ();

   rect_source #(
      .N_ITEMS      (N_ITEMS),
      .A_OFF        (3),
      .B_OFF        (1),
      .SETUP_CYCLES (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err_count (err_count),
      .last_p    (last_p)
`ifdef RECT_SOURCE_TIMEOUT_EN
      ,
      .timeout   (timeout)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: pair and perimeter for item i straight from the rules.
   function automatic int exp_a(input int i);
      return ((i / 2) + 3) % 16;
   endfunction

   function automatic int exp_b(input int i);
      return ((i % 16) + 1) % 16;
   endfunction

   function automatic int exp_p(input int i);
      return (2 * (exp_a(i) + exp_b(i))) % 64;
   endfunction

   // Observations of the most recent run.
   int r_items;
   int r_bad_pairs;
   int r_viol;
   int r_done;
   int r_hold_viol;
   int r_first_fall;
   int r_first_a, r_first_b, r_last_a, r_last_b;

   // One run as the consumer. mask bit k makes item k answer with p+1.
   task automatic do_run(input logic [31:0] mask, input int drop_dly, input int rise_dly,
                         input int hold_low, input bit rand_dly, input int abort_item,
                         input bit pokes);
      int         cyc;
      int         phase;     // 0 wait for dav_ fall, 1 before rfd drop, 2 before rfd rise
      int         wait_cnt;
      int         post;
      int         cur_item;
      int         fault;
      bit         finished;
      bit         aborting;
      bit         seen_done;
      bit         new_item;
      logic       prev_dav;
      logic [3:0] prev_a, prev_b, lat_a, lat_b;

      cyc = 0; phase = 0; wait_cnt = 0; post = 0; cur_item = 0; fault = 0;
      finished = 1'b0; aborting = 1'b0; seen_done = 1'b0;
      lat_a = 4'd0; lat_b = 4'd0;
      r_items = 0; r_bad_pairs = 0; r_viol = 0; r_done = 0; r_hold_viol = 0;
      r_first_fall = -1; r_first_a = -1; r_first_b = -1; r_last_a = -1; r_last_b = -1;

      bus.rfd = (hold_low > 0) ? 1'b0 : 1'b1;
      start   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_busy", int'(busy), 1);
      check("start_a", int'(bus.a), exp_a(0));
      check("start_b", int'(bus.b), exp_b(0));
      check("start_dav", int'(bus.dav_), 1);
      check("start_err", int'(err_count), 0);
      prev_dav = bus.dav_; prev_a = bus.a; prev_b = bus.b;

      while (!finished && cyc < BUDGET) begin
         @(negedge clock);
         cyc++;
         start    = 1'b0;
         new_item = 1'b0;
         if (aborting) begin
            check("rst_dav", int'(bus.dav_), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_a", int'(bus.a), 0);
            check("rst_b", int'(bus.b), 0);
            check("rst_err", int'(err_count), 0);
            check("rst_last_p", int'(last_p), 0);
            reset    = 1'b0;
            bus.rfd  = 1'b1;
            finished = 1'b1;
         end else begin
            // Observe what the last edge produced, using rfd as it was sampled.
            if (done) r_done++;
            if (!bus.dav_ && cyc <= hold_low) r_hold_viol++;
            if (!prev_dav && !bus.dav_ && (bus.a != prev_a || bus.b != prev_b)) r_viol++;
            if (prev_dav && !bus.dav_) begin
               if (!bus.rfd || phase != 0) r_viol++;
               if (r_first_fall < 0) r_first_fall = cyc;
               cur_item = r_items;
               r_items++;
               if (cur_item >= N_ITEMS || int'(bus.a) != exp_a(cur_item) ||
                   int'(bus.b) != exp_b(cur_item)) r_bad_pairs++;
               if (cur_item == 0) begin
                  r_first_a = int'(bus.a);
                  r_first_b = int'(bus.b);
               end
               r_last_a = int'(bus.a);
               r_last_b = int'(bus.b);
               lat_a = bus.a;
               lat_b = bus.b;
               if (cur_item == abort_item) begin
                  check("pre_rst_err", int'(err_count),
                        $countones(mask & ((32'd1 << cur_item) - 32'd1)));
                  reset    = 1'b1;
                  aborting = 1'b1;
               end else begin
                  new_item = 1'b1;
               end
            end

            // Consumer reactions.
            if (hold_low > 0 && cyc == hold_low) bus.rfd = 1'b1;
            if (phase == 1) begin
               wait_cnt--;
               if (wait_cnt == 0) begin
                  fault   = mask[cur_item] ? 1 : 0;
                  bus.rfd = 1'b0;
                  bus.p   = 6'((2 * (int'(lat_a) + int'(lat_b)) + fault) % 64);
                  phase    = 2;
                  wait_cnt = rand_dly ? int'($urandom_range(4, 1)) : rise_dly;
               end
            end else if (phase == 2) begin
               wait_cnt--;
               if (wait_cnt == 0) begin
                  if (!bus.dav_) r_viol++;
                  bus.rfd = 1'b1;
                  phase   = 0;
               end
            end
            if (new_item) begin
               phase    = 1;
               wait_cnt = rand_dly ? int'($urandom_range(4, 1)) : drop_dly;
               if (pokes && cur_item == 10) start = 1'b1;  // ignored while busy
            end

            if (done && !seen_done) begin
               seen_done = 1'b1;
               post      = 3;
               if (pokes) start = 1'b1;                    // ignored in DONE
            end else if (seen_done) begin
               post--;
               if (post == 0) finished = 1'b1;
            end
         end
         prev_dav = bus.dav_; prev_a = bus.a; prev_b = bus.b;
      end
      check("run_finished", int'(finished), 1);
      start   = 1'b0;
      reset   = 1'b0;
      bus.rfd = 1'b1;
   endtask

   typedef struct {
      logic [31:0] mask;
      int          drop;
      int          rise;
      int          hold;
      int          exp_err;
      int          exp_last_p;
   } vec_t;

   vec_t        vt [4];
   logic [31:0] rmask;
   int          to_low;
   int          to_wait;
   bit          to_done;

   initial begin
      vt[0] = '{32'h0000_0000, 2, 3, 0,  0, 4};  // clean consumer
      vt[1] = '{32'h0002_0020, 2, 3, 0,  2, 4};  // items 5 and 17 wrong
      vt[2] = '{32'h8000_0001, 1, 1, 10, 2, 5};  // rfd low at start, last item wrong
      vt[3] = '{32'hFFFF_FFFF, 3, 1, 0, 32, 5};  // every item wrong

      reset   = 1'b1;
      start   = 1'b0;
      bus.rfd = 1'b1;
      bus.p   = 6'd0;
      repeat (2) @(negedge clock);
      check("reset_dav", int'(bus.dav_), 1);
      check("reset_a", int'(bus.a), 0);
      check("reset_b", int'(bus.b), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err_count), 0);
      check("reset_last_p", int'(last_p), 0);
`ifdef RECT_SOURCE_TIMEOUT_EN
      check("reset_timeout", int'(timeout), 0);
`endif
      reset = 1'b0;
      @(negedge clock);

      // Reset while dav_ is low for item 3, after one faulty item was counted.
      do_run(32'h0000_0002, 2, 3, 0, 1'b0, 3, 1'b0);
      repeat (2) @(negedge clock);

      // Table-driven full runs; the first also shows the restart from item 0.
      for (int r = 0; r < 4; r++) begin
         do_run(vt[r].mask, vt[r].drop, vt[r].rise, vt[r].hold, 1'b0, -1, 1'b0);
         check($sformatf("v%0d_items", r), r_items, N_ITEMS);
         check($sformatf("v%0d_pairs", r), r_bad_pairs, 0);
         check($sformatf("v%0d_protocol", r), r_viol, 0);
         check($sformatf("v%0d_hold", r), r_hold_viol, 0);
         check($sformatf("v%0d_first_fall", r), r_first_fall, vt[r].hold + 1);
         check($sformatf("v%0d_done_pulses", r), r_done, 1);
         check($sformatf("v%0d_first_a", r), r_first_a, 3);
         check($sformatf("v%0d_first_b", r), r_first_b, 1);
         check($sformatf("v%0d_last_a", r), r_last_a, 2);
         check($sformatf("v%0d_last_b", r), r_last_b, 0);
         check($sformatf("v%0d_err", r), int'(err_count), vt[r].exp_err);
         check($sformatf("v%0d_last_p", r), int'(last_p), vt[r].exp_last_p);
         check($sformatf("v%0d_busy_end", r), int'(busy), 0);
         check($sformatf("v%0d_dav_end", r), int'(bus.dav_), 1);
      end

      // Random delays and fault masks, with stray start pulses mid-run and in DONE.
      for (int r = 0; r < 3; r++) begin
         rmask = $urandom();
         do_run(rmask, 0, 0, 0, 1'b1, -1, 1'b1);
         check($sformatf("rnd%0d_items", r), r_items, N_ITEMS);
         check($sformatf("rnd%0d_pairs", r), r_bad_pairs, 0);
         check($sformatf("rnd%0d_protocol", r), r_viol, 0);
         check($sformatf("rnd%0d_done_pulses", r), r_done, 1);
         check($sformatf("rnd%0d_err", r), int'(err_count), $countones(rmask));
         check($sformatf("rnd%0d_last_p", r), int'(last_p),
               (exp_p(N_ITEMS - 1) + (rmask[N_ITEMS-1] ? 1 : 0)) % 64);
         check($sformatf("rnd%0d_busy_end", r), int'(busy), 0);
      end

`ifdef RECT_SOURCE_TIMEOUT_EN
      // Consumer never drops rfd: the watchdog must abandon the request.
      to_low  = 0;
      to_wait = 0;
      to_done = 1'b0;
      bus.rfd = 1'b1;
      start   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      while (!to_done && to_wait < 600) begin
         @(negedge clock);
         to_wait++;
         if (!bus.dav_) to_low++;
         if (done) to_done = 1'b1;
      end
      check("to_done", int'(to_done), 1);
      check("to_flag", int'(timeout), 1);
      check("to_dav", int'(bus.dav_), 1);
      check("to_busy", int'(busy), 0);
      check("to_req_cycles", to_low, 255);
      @(negedge clock);
      check("to_sticky", int'(timeout), 1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("to_cleared", int'(timeout), 0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_rect_source
